// File: rtl/bingo_pkg.sv
// Shared types and constants for the bingo draw path.
package bingo_pkg;

    localparam int NUM_BALLS_DEFAULT = 75;
    localparam int BALL_CNT_W        = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CHECK,
        ST_SCAN,
        ST_PRESENT,
        ST_OVER
    } draw_state_t;

endpackage

// File: rtl/bingo_ball_map.sv
// Drawn-ball bitmap: synchronous clear/set, two combinational lookups.
module bingo_ball_map
    import bingo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BALLS  = NUM_BALLS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  set_en,
    input  logic [DATA_WIDTH-1:0] set_idx,
    input  logic [DATA_WIDTH-1:0] chk_idx,
    output logic                  chk_hit,
    input  logic [DATA_WIDTH-1:0] scan_idx,
    output logic                  scan_hit
);

    // Bit 0 is never set; ball values start at 1.
    logic [NUM_BALLS:0] bits;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            bits <= '0;
        end else if (set_en) begin
            for (int i = 1; i <= NUM_BALLS; i++) begin
                if (set_idx == DATA_WIDTH'(i)) bits[i] <= 1'b1;
            end
        end
    end

    // Indices beyond NUM_BALLS read as clear; the caller range-checks them.
    always_comb begin
        chk_hit  = 1'b0;
        scan_hit = 1'b0;
        for (int i = 0; i <= NUM_BALLS; i++) begin
            if (chk_idx == DATA_WIDTH'(i))  chk_hit  = bits[i];
            if (scan_idx == DATA_WIDTH'(i)) scan_hit = bits[i];
        end
    end

endmodule

// File: rtl/bingo_draw_ctrl.sv
// Draw sequencer: samples an external PRNG, rejects invalid/duplicate values,
// falls back to an ascending scan after MAX_TRIES rejects, presents via valid/ready.
module bingo_draw_ctrl
    import bingo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BALLS  = NUM_BALLS_DEFAULT,
    parameter int MAX_TRIES  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  draw_req,
    output logic                  prng_en,
    input  logic [DATA_WIDTH-1:0] prng_num,
    output logic                  ball_valid,
    input  logic                  ball_ready,
    output logic [DATA_WIDTH-1:0] ball,
    output logic [BALL_CNT_W-1:0] ball_count,
    output logic                  busy,
    output logic                  game_over
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    draw_state_t           state, state_nxt;
    logic [TRY_W-1:0]      tries, tries_nxt;
    logic [DATA_WIDTH-1:0] idx, idx_nxt;
    logic [DATA_WIDTH-1:0] ball_nxt;
    logic                  valid_nxt;
    logic [BALL_CNT_W-1:0] count_nxt;
    logic                  map_clr, map_set;
    logic [DATA_WIDTH-1:0] set_idx;
    logic                  chk_hit, scan_hit;
    logic                  num_legal;

    bingo_ball_map #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_BALLS (NUM_BALLS)
    ) u_map (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (map_clr),
        .set_en  (map_set),
        .set_idx (set_idx),
        .chk_idx (prng_num),
        .chk_hit (chk_hit),
        .scan_idx(idx),
        .scan_hit(scan_hit)
    );

    assign num_legal = (prng_num != '0) && (prng_num <= DATA_WIDTH'(NUM_BALLS)) && !chk_hit;
    assign busy      = (state != ST_IDLE) && (state != ST_OVER);
    assign game_over = (state == ST_OVER);

    always_comb begin
        state_nxt = state;
        tries_nxt = tries;
        idx_nxt   = idx;
        ball_nxt  = ball;
        valid_nxt = ball_valid;
        count_nxt = ball_count;
        map_clr   = 1'b0;
        map_set   = 1'b0;
        set_idx   = prng_num;
        prng_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (draw_req) begin
                    state_nxt = ST_SAMPLE;
                    tries_nxt = '0;
                end
            end
            ST_SAMPLE: begin
                prng_en   = 1'b1;
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (num_legal) begin
                    ball_nxt  = prng_num;
                    map_set   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = ST_PRESENT;
                end else begin
                    tries_nxt = tries + 1'b1;
                    if (tries == TRY_W'(MAX_TRIES - 1)) begin
                        idx_nxt   = DATA_WIDTH'(1);
                        state_nxt = ST_SCAN;
                    end else begin
                        state_nxt = ST_SAMPLE;
                    end
                end
            end
            ST_SCAN: begin
                if (!scan_hit) begin
                    ball_nxt  = idx;
                    set_idx   = idx;
                    map_set   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = ST_PRESENT;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            ST_PRESENT: begin
                if (ball_ready) begin
                    valid_nxt = 1'b0;
                    count_nxt = ball_count + 1'b1;
                    state_nxt = (count_nxt == BALL_CNT_W'(NUM_BALLS)) ? ST_OVER : ST_IDLE;
                end
            end
            ST_OVER: ;
            default: state_nxt = ST_IDLE;
        endcase
        // A new game wins over everything except reset, including a same-cycle handshake.
        if (start) begin
            state_nxt = ST_IDLE;
            tries_nxt = '0;
            valid_nxt = 1'b0;
            count_nxt = '0;
            map_clr   = 1'b1;
            map_set   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            tries      <= '0;
            idx        <= '0;
            ball       <= '0;
            ball_valid <= 1'b0;
            ball_count <= '0;
        end else begin
            state      <= state_nxt;
            tries      <= tries_nxt;
            idx        <= idx_nxt;
            ball       <= ball_nxt;
            ball_valid <= valid_nxt;
            ball_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_bingo_draw_ctrl.sv
// Self-checking bench for bingo_draw_ctrl with a behavioural PRNG and draw model.
module tb_bingo_draw_ctrl;

    logic       clk = 1'b0;
    logic       rstn, start, draw_req, ball_ready;
    logic       prng_en, ball_valid, busy, game_over;
    logic [7:0] prng_num, ball;
    logic [6:0] ball_count;

    int checks = 0;
    int errors = 0;
    int prng_mode = 0;          // 0: stub queue then random, 1: LFSR
    logic [7:0] stub_q[$];
    logic [7:0] samp_q[$];
    bit drawn_m[0:255];

    always #5 clk = ~clk;

    bingo_draw_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start), .draw_req(draw_req),
        .prng_en(prng_en), .prng_num(prng_num), .ball_valid(ball_valid),
        .ball_ready(ball_ready), .ball(ball), .ball_count(ball_count),
        .busy(busy), .game_over(game_over)
    );

    // External PRNG model: advances once per prng_en pulse.
    always @(posedge clk) begin
        logic [7:0] nv;
        if (!rstn) begin
            prng_num <= 8'd0;
        end else if (prng_en) begin
            if (stub_q.size() > 0)   nv = stub_q.pop_front();
            else if (prng_mode == 1) nv = {prng_num[6:0], 1'b0} ^ (prng_num[7] ? 8'h1D : 8'h00);
            else                     nv = 8'($urandom_range(0, 100));
            prng_num <= nv;
            samp_q.push_back(nv);
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0; start = 1'b0; draw_req = 1'b0; ball_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        stub_q.delete(); samp_q.delete();
    endtask

    // Pulses draw_req; n counts cycles after the cycle in which it was sampled.
    task automatic draw(input int budget, output int valid_at, output int pulses,
                        output int first_pulse, output logic [7:0] b);
        valid_at = -1; pulses = 0; first_pulse = -1; b = 8'd0;
        @(negedge clk);
        draw_req = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (n == 1) draw_req = 1'b0;
            if (prng_en) begin
                pulses++;
                if (first_pulse < 0) first_pulse = n;
            end
            if (ball_valid) begin
                valid_at = n; b = ball;
                break;
            end
        end
        if (valid_at < 0) begin
            checks++; errors++;
            $display("FAIL draw_timeout: no ball_valid within %0d cycles", budget);
        end
    endtask

    task automatic accept();
        ball_ready = 1'b1;
        @(negedge clk);
        ball_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; draw_req = 1'b0; ball_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ball_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ball_valid); end
        checks++; if (ball !== 8'd0) begin errors++; $display("FAIL reset_ball: got %0d want 0", ball); end
        checks++; if (ball_count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", ball_count); end
        checks++; if ({prng_en, busy, game_over} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {prng_en, busy, game_over}); end
        rstn = 1'b1;
    endtask

    task automatic test_latency();
        int va, p, fp; logic [7:0] b;
        apply_reset();
        stub_q.push_back(8'd5);
        draw(20, va, p, fp, b);
        checks++; if (fp !== 1 || p !== 1) begin errors++; $display("FAIL lat_prng_en: first %0d pulses %0d want 1 1", fp, p); end
        checks++; if (va !== 3) begin errors++; $display("FAIL lat_valid: got T+%0d want T+3", va); end
        checks++; if (b !== 8'd5) begin errors++; $display("FAIL lat_ball: got %0d want 5", b); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (ball !== 8'd5 || ball_valid !== 1'b1) begin errors++; $display("FAIL hold_ball: got %0d/%b want 5/1", ball, ball_valid); end
        end
        accept();
        checks++; if (ball_count !== 7'd1 || ball_valid !== 1'b0) begin errors++; $display("FAIL lat_count: got %0d/%b want 1/0", ball_count, ball_valid); end
    endtask

    task automatic test_retry();
        int va, p, fp; logic [7:0] b;
        stub_q = '{8'd5, 8'd5, 8'd200, 8'd0, 8'd9};
        draw(40, va, p, fp, b);
        checks++; if (p !== 5) begin errors++; $display("FAIL retry_pulses: got %0d want 5", p); end
        checks++; if (va !== 11) begin errors++; $display("FAIL retry_valid: got T+%0d want T+11", va); end
        checks++; if (b !== 8'd9) begin errors++; $display("FAIL retry_ball: got %0d want 9", b); end
        accept();
        checks++; if (ball_count !== 7'd2) begin errors++; $display("FAIL retry_count: got %0d want 2", ball_count); end
    endtask

    task automatic test_stuck_lfsr();
        int va, p, fp; logic [7:0] b;
        apply_reset();
        prng_mode = 1;
        draw(100, va, p, fp, b);
        checks++; if (p !== 16) begin errors++; $display("FAIL scan_pulses: got %0d want 16", p); end
        checks++; if (va !== 34) begin errors++; $display("FAIL scan_valid: got T+%0d want T+34", va); end
        checks++; if (b !== 8'd1) begin errors++; $display("FAIL scan_ball: got %0d want 1", b); end
        accept();
        for (int k = 2; k <= 4; k++) begin
            draw(100, va, p, fp, b);
            checks++; if (b !== 8'(k)) begin errors++; $display("FAIL scan_seq: got %0d want %0d", b, k); end
            accept();
        end
    endtask

    task automatic test_start();
        int va, p, fp; logic [7:0] b;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (ball_count !== 7'd0) begin errors++; $display("FAIL start_idle_count: got %0d want 0", ball_count); end
        draw(100, va, p, fp, b);
        accept();
        @(negedge clk);
        draw_req = 1'b1;
        for (int n = 1; n <= 33; n++) begin
            @(negedge clk);
            if (n == 1) draw_req = 1'b0;
        end
        checks++; if (busy !== 1'b1 || ball_valid !== 1'b0) begin errors++; $display("FAIL start_in_scan: busy/valid %b%b want 10", busy, ball_valid); end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if ({busy, ball_valid, ball_count} !== 9'd0) begin errors++; $display("FAIL start_scan_clear: busy %b valid %b count %0d want 0 0 0", busy, ball_valid, ball_count); end
        checks++; if (ball !== 8'd1) begin errors++; $display("FAIL start_ball_kept: got %0d want 1", ball); end
        draw(100, va, p, fp, b);
        checks++; if (b !== 8'd1 || va !== 34) begin errors++; $display("FAIL start_redraw: got %0d at T+%0d want 1 at T+34", b, va); end
        ball_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        ball_ready = 1'b0; start = 1'b0;
        checks++; if ({busy, ball_valid, ball_count} !== 9'd0) begin errors++; $display("FAIL start_present_clear: busy %b valid %b count %0d want 0 0 0", busy, ball_valid, ball_count); end
        draw(100, va, p, fp, b);
        checks++; if (b !== 8'd1) begin errors++; $display("FAIL start_map_clear: got %0d want 1", b); end
        accept();
        checks++; if (ball_count !== 7'd1) begin errors++; $display("FAIL start_count: got %0d want 1", ball_count); end
    endtask

    task automatic test_rstn_override();
        prng_mode = 0;
        stub_q = '{8'd7};
        @(negedge clk); draw_req = 1'b1;
        @(negedge clk); draw_req = 1'b0;
        @(negedge clk);
        rstn = 1'b0; start = 1'b1;
        @(negedge clk);
        checks++; if ({prng_en, ball_valid, busy, game_over, ball, ball_count} !== 19'd0) begin
            errors++;
            $display("FAIL rstn_override: en %b valid %b busy %b over %b ball %0d count %0d want all 0",
                     prng_en, ball_valid, busy, game_over, ball, ball_count);
        end
        rstn = 1'b1; start = 1'b0;
        stub_q.delete(); samp_q.delete();
    endtask

    task automatic test_full_game();
        int va, p, fp, exp_p, seen_en, seen_v;
        logic [7:0] b, exp_b;
        prng_mode = 0;
        for (int v = 0; v < 256; v++) drawn_m[v] = 1'b0;
        for (int d = 0; d < 75; d++) begin
            samp_q.delete();
            draw(300, va, p, fp, b);
            exp_b = 8'd0; exp_p = 16;
            for (int k = 0; k < 16 && k < samp_q.size(); k++) begin
                if (samp_q[k] >= 8'd1 && samp_q[k] <= 8'd75 && !drawn_m[samp_q[k]]) begin
                    exp_b = samp_q[k]; exp_p = k + 1;
                    break;
                end
            end
            if (exp_b == 8'd0) begin
                for (int v = 75; v >= 1; v--) if (!drawn_m[v]) exp_b = 8'(v);
            end
            checks++; if (b !== exp_b) begin errors++; $display("FAIL game_ball[%0d]: got %0d want %0d", d, b, exp_b); end
            checks++; if (samp_q.size() !== exp_p) begin errors++; $display("FAIL game_pulses[%0d]: got %0d want %0d", d, samp_q.size(), exp_p); end
            drawn_m[exp_b] = 1'b1;
            accept();
        end
        checks++; if (ball_count !== 7'd75 || game_over !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL game_end: count %0d over %b busy %b want 75 1 0", ball_count, game_over, busy);
        end
        seen_en = 0; seen_v = 0;
        draw_req = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (prng_en) seen_en++;
            if (ball_valid) seen_v++;
        end
        draw_req = 1'b0;
        checks++; if (seen_en !== 0 || seen_v !== 0 || game_over !== 1'b1) begin
            errors++; $display("FAIL game_over_ignore: prng_en %0d valid %0d over %b want 0 0 1", seen_en, seen_v, game_over);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_retry();
        test_stuck_lfsr();
        test_start();
        test_rstn_override();
        test_full_game();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
